// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Counters must be able to hold the value DEPTH itself, not just DEPTH-1.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO with occupancy count and optional synchronous flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  input  logic                        flush,
  output logic [WIDTH-1:0]            pop_data,
  output logic [cnt_w(DEPTH)-1:0]     count,
  output logic                        full,
  output logic                        empty
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wr_ptr] <= push_data;
  end

  assign pop_data = r_mem[r_rd_ptr];
  assign count    = r_count;
  assign full     = (r_count == CNT_W'(DEPTH));
  assign empty    = (r_count == '0);

  a_no_overflow:  assert property (@(posedge clk) disable iff (!reset) !(push && full && !pop && !flush));
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset) !(pop && empty && !flush));

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: credit-limited imem requests, in-order response buffering,
// redirect handling with a drop counter for stale in-flight responses.
module if_fetch_stage
  import fetch_pkg::*;
#(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  output logic        pc_en,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stallD,
  input  logic        flushD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        validD
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int ENT_W = $bits(fetch_entry_t);

  logic [CNT_W-1:0] r_inflight;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [31:0]      r_pcd_hold;

  logic             w_credit;
  logic             w_fire;
  logic [31:0]      w_pend_pc;
  logic [CNT_W-1:0] w_pend_cnt;
  logic             w_pend_full;
  logic             w_pend_empty;
  logic             w_q_push;
  logic             w_q_pop;
  fetch_entry_t     w_q_in;
  logic [ENT_W-1:0] w_q_dout;
  fetch_entry_t     w_q_head;
  logic [CNT_W-1:0] w_q_cnt;
  logic             w_q_full;
  logic             w_q_empty;

  assign w_credit       = ({1'b0, r_inflight} + {1'b0, w_q_cnt}) < (CNT_W+1)'(DEPTH);
  assign imem_req_valid = w_credit & ~flushD & reset;
  assign imem_req_addr  = PC;
  assign w_fire         = imem_req_valid & imem_req_ready;
  assign pc_en          = (w_fire | flushD) & reset;

  // Responses owed to requests issued before a redirect are swallowed here.
  assign w_q_push = imem_rsp_valid & (r_drop_cnt == '0) & ~flushD;
  assign w_q_pop  = validD & ~stallD & ~flushD;
  assign w_q_in   = '{pc: w_pend_pc, instr: imem_rsp_data};
  assign w_q_head = fetch_entry_t'(w_q_dout);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inflight <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_inflight <= r_inflight + CNT_W'(w_fire) - CNT_W'(imem_rsp_valid);
      if (flushD)
        r_drop_cnt <= r_inflight - CNT_W'(imem_rsp_valid) + CNT_W'(w_fire);
      else if (imem_rsp_valid && (r_drop_cnt != '0))
        r_drop_cnt <= r_drop_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          r_pcd_hold <= '0;
    else if (!w_q_empty) r_pcd_hold <= w_q_head.pc;
  end

  fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pend_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_fire),
    .push_data (PC),
    .pop       (imem_rsp_valid),
    .flush     (1'b0),
    .pop_data  (w_pend_pc),
    .count     (w_pend_cnt),
    .full      (w_pend_full),
    .empty     (w_pend_empty)
  );

  fetch_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_instr_q (
    .clk       (clk),
    .reset     (reset),
    .push      (w_q_push),
    .push_data (w_q_in),
    .pop       (w_q_pop),
    .flush     (flushD),
    .pop_data  (w_q_dout),
    .count     (w_q_cnt),
    .full      (w_q_full),
    .empty     (w_q_empty)
  );

  assign validD   = ~w_q_empty;
  assign InstrD   = w_q_empty ? NOP_INSTR : w_q_head.instr;
  assign PCD      = w_q_empty ? r_pcd_hold : w_q_head.pc;
  assign PCPlus4D = PCD + 32'd4;

  a_rsp_has_req:  assert property (@(posedge clk) disable iff (!reset) imem_rsp_valid |-> (r_inflight != '0 && !w_pend_empty));
  a_pend_match:   assert property (@(posedge clk) disable iff (!reset) w_pend_cnt == r_inflight);
  a_pend_no_ovf:  assert property (@(posedge clk) disable iff (!reset) !(w_fire && w_pend_full));
  a_queue_no_ovf: assert property (@(posedge clk) disable iff (!reset) !(w_q_push && w_q_full && !w_q_pop));

endmodule
